// File: rtl/eth_pcs_params.sv
// Shared constants, sync-header helpers and FSM state type for the PCS receive
// block-lock path.
package eth_pcs_params;

  localparam int W_SYNC    = 2;
  localparam int W_BER_CNT = 6;

  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } sync_state_e;

  function automatic logic hdr_is_valid(input logic [W_SYNC-1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_pcs_rx_ber_mon.sv
// Windowed invalid-header counter and high-BER flag; only active while block
// lock is held.
module eth_pcs_rx_ber_mon
  import eth_pcs_params::*;
#(
  parameter int P_BER_WINDOW = 40283,
  parameter int P_BAD_LIMIT  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_lock,
  input  logic                 i_valid,
  input  logic                 i_hdr_bad,
  output logic                 o_hi_ber,
  output logic [W_BER_CNT-1:0] o_ber_cnt
);

  localparam int                   W_TMR    = (P_BER_WINDOW > 1) ? $clog2(P_BER_WINDOW) : 1;
  localparam logic [W_TMR-1:0]     TMR_LAST = W_TMR'(P_BER_WINDOW - 1);
  localparam logic [W_BER_CNT-1:0] CNT_MAX  = '1;

  function automatic logic [W_BER_CNT-1:0] sat_inc(input logic [W_BER_CNT-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [W_TMR-1:0]     r_tmr;
  logic [W_BER_CNT-1:0] r_ber_cnt;
  logic                 r_hi_ber;
  logic                 w_wrap;
  logic                 w_bad_strobe;
  logic                 w_over;

  assign w_wrap       = (r_tmr == TMR_LAST);
  assign w_bad_strobe = i_valid & i_hdr_bad;
  assign w_over       = (int'(r_ber_cnt) >= P_BAD_LIMIT);

  // The wrap cycle judges the closing window on its final count, while a bad
  // header arriving in that same cycle opens the new window at 1.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tmr     <= '0;
      r_ber_cnt <= '0;
      r_hi_ber  <= 1'b0;
    end else if (!i_lock) begin
      r_tmr     <= '0;
      r_ber_cnt <= '0;
      r_hi_ber  <= 1'b0;
    end else if (w_wrap) begin
      r_tmr     <= '0;
      r_ber_cnt <= w_bad_strobe ? W_BER_CNT'(1) : '0;
      r_hi_ber  <= w_over;
    end else begin
      r_tmr     <= r_tmr + 1'b1;
      r_hi_ber  <= r_hi_ber | w_over;
      if (w_bad_strobe) r_ber_cnt <= sat_inc(r_ber_cnt);
    end
  end

  assign o_hi_ber  = r_hi_ber;
  assign o_ber_cnt = r_ber_cnt;

endmodule

// File: rtl/eth_pcs_rx_sync_ctrl.sv
// Receive block-lock controller: hunts for a stable sync-header alignment,
// requests gearbox slips, and monitors header error rate once locked.
module eth_pcs_rx_sync_ctrl
  import eth_pcs_params::*;
#(
  parameter int P_LOCK_CNT     = 64,
  parameter int P_BAD_LIMIT    = 16,
  parameter int P_SLIP_HOLDOFF = 4,
  parameter int P_BER_WINDOW   = 40283
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  input  logic [W_SYNC-1:0]    i_sync_hdr,
  output logic                 o_slip,
  output logic                 o_rx_lock,
  output logic                 o_hi_ber,
  output logic [W_BER_CNT-1:0] o_ber_cnt
);

  localparam int W_SH   = $clog2(P_LOCK_CNT + 1);
  localparam int W_BAD  = $clog2(P_BAD_LIMIT + 1);
  localparam int W_HOLD = (P_SLIP_HOLDOFF > 0) ? $clog2(P_SLIP_HOLDOFF + 1) : 1;

  localparam logic [W_SH-1:0]   SH_LAST   = W_SH'(P_LOCK_CNT);
  localparam logic [W_BAD-1:0]  BAD_LAST  = W_BAD'(P_BAD_LIMIT);
  localparam logic [W_HOLD-1:0] HOLD_LAST = W_HOLD'(P_SLIP_HOLDOFF);

  sync_state_e       r_state, w_state_nxt;
  logic [W_SH-1:0]   r_sh_cnt, w_sh_nxt, w_sh_inc;
  logic [W_BAD-1:0]  r_bad_cnt, w_bad_nxt, w_bad_inc;
  logic [W_HOLD-1:0] r_hold_cnt, w_hold_nxt, w_hold_inc;
  logic              r_slip, w_slip_nxt;
  logic              w_hdr_bad;

  assign w_hdr_bad = ~hdr_is_valid(i_sync_hdr);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_HUNT;
      r_sh_cnt   <= '0;
      r_bad_cnt  <= '0;
      r_hold_cnt <= '0;
      r_slip     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sh_cnt   <= w_sh_nxt;
      r_bad_cnt  <= w_bad_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_slip     <= w_slip_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh_cnt;
    w_bad_nxt   = r_bad_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_slip_nxt  = 1'b0;
    w_sh_inc    = r_sh_cnt + 1'b1;
    w_bad_inc   = r_bad_cnt + W_BAD'(w_hdr_bad);
    w_hold_inc  = r_hold_cnt + 1'b1;
    if (i_valid) begin
      unique case (r_state)
        ST_HUNT: begin
          if (w_hdr_bad) begin
            w_sh_nxt    = '0;
            w_hold_nxt  = '0;
            w_slip_nxt  = 1'b1;
            w_state_nxt = ST_SLIP_WAIT;
          end else if (w_sh_inc == SH_LAST) begin
            w_sh_nxt    = '0;
            w_state_nxt = ST_LOCKED;
          end else begin
            w_sh_nxt = w_sh_inc;
          end
        end
        ST_SLIP_WAIT: begin
          if (w_hold_inc == HOLD_LAST) begin
            w_hold_nxt  = '0;
            w_sh_nxt    = '0;
            w_bad_nxt   = '0;
            w_state_nxt = ST_HUNT;
          end else begin
            w_hold_nxt = w_hold_inc;
          end
        end
        ST_LOCKED: begin
          // Reaching the bad limit wins over a coincident window end.
          if (w_bad_inc == BAD_LAST) begin
            w_sh_nxt    = '0;
            w_bad_nxt   = '0;
            w_hold_nxt  = '0;
            w_slip_nxt  = 1'b1;
            w_state_nxt = ST_SLIP_WAIT;
          end else if (w_sh_inc == SH_LAST) begin
            w_sh_nxt  = '0;
            w_bad_nxt = '0;
          end else begin
            w_sh_nxt  = w_sh_inc;
            w_bad_nxt = w_bad_inc;
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    o_slip    = r_slip;
    o_rx_lock = (r_state == ST_LOCKED);
  end

  eth_pcs_rx_ber_mon #(
    .P_BER_WINDOW (P_BER_WINDOW),
    .P_BAD_LIMIT  (P_BAD_LIMIT)
  ) u_ber_mon (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_lock    (o_rx_lock),
    .i_valid   (i_valid),
    .i_hdr_bad (w_hdr_bad),
    .o_hi_ber  (o_hi_ber),
    .o_ber_cnt (o_ber_cnt)
  );

endmodule

// File: doc/eth_pcs_rx_sync_ctrl.md
ETH_PCS_RX_SYNC_CTRL -- requirements
Module: eth_pcs_rx_sync_ctrl

Interface
REQ-001 SHALL have parameter P_LOCK_CNT, default 64, meaning headers per test window.
REQ-002 SHALL have parameter P_BAD_LIMIT, default 16, meaning invalid headers per window that cause a slip.
REQ-003 SHALL have parameter P_SLIP_HOLDOFF, default 4, meaning i_valid strobes ignored after each slip.
REQ-004 SHALL have parameter P_BER_WINDOW, default 40283, meaning BER timer period in i_clk cycles (125 us).
REQ-005 SHALL have port i_clk, input, 1, the only clock.
REQ-006 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_valid, input, 1, sync-header strobe from the gearbox.
REQ-008 SHALL have port i_sync_hdr, input, W_SYNC, candidate sync header.
REQ-009 SHALL have port o_slip, output, 1, one-cycle slip request to the gearbox.
REQ-010 SHALL have port o_rx_lock, output, 1, block lock.
REQ-011 SHALL have port o_hi_ber, output, 1, high bit error rate.
REQ-012 SHALL have port o_ber_cnt, output, 6, invalid-header count in the current BER window.

Function
REQ-013 Header valid SHALL mean i_sync_hdr is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid; i_sync_hdr SHALL be ignored when i_valid=0.
REQ-014 FSM SHALL have three states: ST_HUNT, ST_SLIP_WAIT and ST_LOCKED.
REQ-015 In ST_HUNT, each valid strobe SHALL increment sh_cnt; on the P_LOCK_CNT-th consecutive valid strobe the FSM SHALL enter ST_LOCKED and set o_rx_lock on the next cycle.
REQ-016 In ST_HUNT, an invalid strobe SHALL clear sh_cnt, pulse o_slip and enter ST_SLIP_WAIT.
REQ-017 In ST_LOCKED, each strobe SHALL increment sh_cnt, and each invalid strobe SHALL also increment bad_cnt.
REQ-018 In ST_LOCKED, when sh_cnt reaches P_LOCK_CNT with bad_cnt < P_BAD_LIMIT, both counters SHALL clear and the FSM SHALL stay locked.
REQ-019 In ST_LOCKED, when bad_cnt reaches P_BAD_LIMIT, the FSM SHALL clear o_rx_lock, pulse o_slip, clear both counters and enter ST_SLIP_WAIT; this condition SHALL take priority if it coincides with the window end.
REQ-020 o_slip SHALL be registered, high for exactly one i_clk cycle, in the cycle after the triggering strobe, and never high on two consecutive cycles.
REQ-021 In ST_SLIP_WAIT, P_SLIP_HOLDOFF strobes SHALL be discarded without evaluation; the FSM SHALL then enter ST_HUNT with counters cleared.
REQ-022 Cycles with i_valid=0 SHALL change no counter or state, except the BER timer.
REQ-023 The BER timer SHALL run only while o_rx_lock=1, count 0..P_BER_WINDOW-1 and wrap.
REQ-024 While locked, each invalid strobe SHALL increment o_ber_cnt, saturating at 63.
REQ-025 o_hi_ber SHALL set in the cycle after o_ber_cnt reaches P_BAD_LIMIT.
REQ-026 On timer wrap, o_ber_cnt SHALL clear; o_hi_ber SHALL clear if the count stayed below P_BAD_LIMIT.
REQ-027 An invalid strobe in the wrap cycle SHALL count into the new window (o_ber_cnt=1).
REQ-028 When o_rx_lock=0, the timer, o_ber_cnt and o_hi_ber SHALL be held at 0.

Reset
REQ-029 Asserting i_reset_n low SHALL immediately set ST_HUNT, all counters to 0, and o_slip, o_rx_lock, o_hi_ber and o_ber_cnt to 0, including mid-window and mid-holdoff.
REQ-030 After reset release, operation SHALL begin on the first i_clk edge.

Structure
REQ-031 W_SYNC, constants SYNC_DATA=2'b01 and SYNC_CTRL=2'b10, and the FSM state typedef SHALL live in eth_pcs_params.
REQ-032 The BER timer and counter SHALL be a sub-module eth_pcs_rx_ber_mon, with i_clk, i_reset_n, i_lock, i_valid and i_hdr_bad inputs.
REQ-033 Counter widths SHALL derive from the parameters via $clog2.

Verification
REQ-034 Reset, then 64 strobes of 2'b01 -> o_rx_lock=1 one cycle after the 64th strobe; o_slip stays 0.
REQ-035 In ST_HUNT, valid strobes 1..10, then 2'b11 on strobe 11 -> o_slip=1 for 1 cycle; the next 4 strobes are ignored; lock comes after 64 further valid strobes.
REQ-036 Locked, 15 invalid strobes in a 64-strobe window -> lock is held and counters clear; 16 invalid strobes in one window -> o_rx_lock=0 and one o_slip pulse.
REQ-037 Locked, P_BER_WINDOW=100, 16 invalid strobes spread under the 16-per-64 limit within 100 cycles -> o_hi_ber=1; an error-free next window -> o_hi_ber=0 and o_ber_cnt=0 at wrap.
REQ-038 An invalid strobe exactly at timer wrap -> o_ber_cnt=1 in the new window.
REQ-039 i_reset_n pulsed low during ST_SLIP_WAIT and during o_hi_ber=1 -> all outputs are 0 asynchronously; the FSM restarts in ST_HUNT.
